// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding request controller in front of a registered-read memory bank,
// with range checking and a saturating error counter.
`ifndef DATA_WORD_SIZE
`define DATA_WORD_SIZE 16
`endif
`ifndef DATA_ADDR_SIZE
`define DATA_ADDR_SIZE 8
`endif
module mem_access_ctrl #(
  parameter int word_size = `DATA_WORD_SIZE,
  parameter int addr_size = `DATA_ADDR_SIZE,
  parameter int depth = 2 ** addr_size
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [addr_size-1:0] req_addr,
  input  logic [word_size-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [word_size-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_w_en,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_d_in,
  input  logic [word_size-1:0] mem_d_out,
  output logic [7:0]           err_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  // one extra bit so depth == 2**addr_size is representable
  localparam logic [addr_size:0] depth_w = (addr_size+1)'(depth);
  state_t state;
  logic lat_we;
  logic [addr_size-1:0] lat_addr;
  logic [word_size-1:0] lat_wdata;
  logic in_range;
  assign in_range = {1'b0, req_addr} < depth_w;
  assign req_ready = (state == IDLE) & ~rst;
  assign mem_w_en = (state == ACCESS) & lat_we & ~rst;
  assign mem_addr = lat_addr;
  assign mem_d_in = lat_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      err_count <= '0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_we <= req_we;
          lat_addr <= req_addr;
          lat_wdata <= req_wdata;
          if (in_range) state <= ACCESS;
          else begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
            resp_rdata <= '0;
            err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
          end
        end
        ACCESS: if (lat_we) begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_err <= 1'b0;
          resp_rdata <= '0;
        end else state <= CAPTURE;
        CAPTURE: begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_err <= 1'b0;
          resp_rdata <= mem_d_out;
        end
        RESP: if (resp_ready) begin
          state <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scenario bench for mem_access_ctrl with a behavioural registered-read memory.
module tb_mem_access_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, resp_ready = 0;
  logic [7:0] req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_w_en;
  logic [15:0] resp_rdata, mem_d_in;
  logic [15:0] mem_d_out;
  logic [7:0] mem_addr, err_count;
  logic [15:0] mem [256] = '{default: 16'h0};
  int checks = 0, errors = 0;
  int lat;
  bit saw_wen;

  mem_access_ctrl #(.word_size(16), .addr_size(8), .depth(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_d_in(mem_d_in), .mem_d_out(mem_d_out), .err_count(err_count));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_d_in;
    mem_d_out <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [7:0] a, input logic [15:0] d);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 0;
  endtask

  task automatic wait_resp();
    lat = 0; saw_wen = 0;
    while (!resp_valid && lat < 10) begin
      if (mem_w_en) saw_wen = 1;
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1;
    tick();
    resp_ready = 0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL handshake: valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++;
    if (req_ready !== 0 || resp_valid !== 0 || err_count !== 0 || mem_w_en !== 0 || mem_addr !== 0)
    begin errors++; $display("FAIL reset_state: rdy=%b vld=%b ec=%0d wen=%b addr=%0d want 0s", req_ready, resp_valid, err_count, mem_w_en, mem_addr); end
    rst = 0; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release: ready=%b want 1", req_ready); end
  endtask

  task automatic test_write();
    issue(1, 8'd3, 16'hBEEF);
    checks++;
    if (mem_w_en !== 1 || mem_addr !== 8'd3 || mem_d_in !== 16'hBEEF || resp_valid !== 0 || req_ready !== 0)
    begin errors++; $display("FAIL write_access: wen=%b addr=%0d din=%h vld=%b rdy=%b want 1/3/beef/0/0", mem_w_en, mem_addr, mem_d_in, resp_valid, req_ready); end
    tick();
    checks++;
    if (mem_w_en !== 0 || resp_valid !== 1 || resp_rdata !== 0 || resp_err !== 0)
    begin errors++; $display("FAIL write_resp: wen=%b vld=%b rd=%h err=%b want 0/1/0/0", mem_w_en, resp_valid, resp_rdata, resp_err); end
    handshake();
  endtask

  task automatic test_read();
    issue(0, 8'd3, 16'h0);
    wait_resp();
    checks++;
    if (lat !== 2 || saw_wen || resp_rdata !== 16'hBEEF || resp_err !== 0)
    begin errors++; $display("FAIL read_addr3: lat=%0d wen_seen=%b rd=%h err=%b want 2/0/beef/0", lat, saw_wen, resp_rdata, resp_err); end
    handshake();
  endtask

  task automatic test_range_boundary();
    issue(1, 8'd15, 16'h1234);
    wait_resp();
    checks++;
    if (lat !== 1 || resp_err !== 0) begin errors++; $display("FAIL write_addr15: lat=%0d err=%b want 1/0", lat, resp_err); end
    handshake();
    issue(0, 8'd15, 16'h0);
    wait_resp();
    checks++;
    if (lat !== 2 || resp_rdata !== 16'h1234 || resp_err !== 0 || err_count !== 0)
    begin errors++; $display("FAIL read_addr15: lat=%0d rd=%h err=%b ec=%0d want 2/1234/0/0", lat, resp_rdata, resp_err, err_count); end
    handshake();
  endtask

  task automatic test_err();
    issue(0, 8'd16, 16'h0);
    checks++;
    if (resp_valid !== 1 || resp_err !== 1 || resp_rdata !== 0 || err_count !== 8'd1 || mem_w_en !== 0)
    begin errors++; $display("FAIL err_addr16: vld=%b err=%b rd=%h ec=%0d wen=%b want 1/1/0/1/0", resp_valid, resp_err, resp_rdata, err_count, mem_w_en); end
    handshake();
    issue(1, 8'd255, 16'hFFFF);
    checks++;
    if (resp_valid !== 1 || resp_err !== 1 || err_count !== 8'd2 || mem_w_en !== 0)
    begin errors++; $display("FAIL err_addr255_write: vld=%b err=%b ec=%0d wen=%b want 1/1/2/0", resp_valid, resp_err, err_count, mem_w_en); end
    handshake();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 253; i++) begin
      issue(0, 8'd16, 16'h0);
      handshake();
    end
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL err_count_255: got %0d want 255", err_count); end
    issue(0, 8'd200, 16'h0);
    handshake();
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL err_count_sat: got %0d want 255", err_count); end
  endtask

  task automatic test_back_to_back();
    issue(0, 8'd3, 16'h0);
    wait_resp();
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_latency: got %0d want 2", lat); end
    req_valid = 1; req_we = 1; req_addr = 8'd4; req_wdata = 16'h0404;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1 || resp_rdata !== 16'hBEEF || req_ready !== 0 || mem_addr !== 8'd3)
      begin errors++; $display("FAIL bp_hold%0d: vld=%b rd=%h rdy=%b addr=%0d want 1/beef/0/3", i, resp_valid, resp_rdata, req_ready, mem_addr); end
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    checks++;
    if (resp_valid !== 0 || req_ready !== 1) begin errors++; $display("FAIL b2b_idle: vld=%b rdy=%b want 0/1", resp_valid, req_ready); end
    tick();
    req_valid = 0;
    checks++;
    if (mem_w_en !== 1 || mem_addr !== 8'd4 || mem_d_in !== 16'h0404)
    begin errors++; $display("FAIL b2b_accept: wen=%b addr=%0d din=%h want 1/4/0404", mem_w_en, mem_addr, mem_d_in); end
    tick();
    checks++;
    if (resp_valid !== 1 || resp_err !== 0) begin errors++; $display("FAIL b2b_resp: vld=%b err=%b want 1/0", resp_valid, resp_err); end
    handshake();
  endtask

  task automatic test_reset_mid();
    issue(1, 8'd5, 16'h0055);
    wait_resp();
    handshake();
    issue(1, 8'd5, 16'hDEAD);
    rst = 1; #1;
    checks++;
    if (mem_w_en !== 0 || req_ready !== 0) begin errors++; $display("FAIL rst_access: wen=%b rdy=%b want 0/0", mem_w_en, req_ready); end
    tick();
    checks++;
    if (resp_valid !== 0 || resp_rdata !== 0 || resp_err !== 0 || err_count !== 0 || mem_addr !== 0 || mem_d_in !== 0 || mem_w_en !== 0)
    begin errors++; $display("FAIL rst_outputs: vld=%b rd=%h err=%b ec=%0d addr=%0d din=%h wen=%b want all 0", resp_valid, resp_rdata, resp_err, err_count, mem_addr, mem_d_in, mem_w_en); end
    rst = 0; #1;
    checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    issue(0, 8'd5, 16'h0);
    wait_resp();
    checks++;
    if (lat !== 2 || resp_rdata !== 16'h0055) begin errors++; $display("FAIL rst_old_value: lat=%0d rd=%h want 2/0055", lat, resp_rdata); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_range_boundary();
    test_err();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
